// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the VGA framebuffer arbiter slice.
package vga_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  // 640x480 @ 60 Hz raster geometry on the 25.175 MHz pixel clock
  localparam int H_TOTAL  = 800;
  localparam int H_ACTIVE = 640;
  localparam int V_TOTAL  = 525;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    CPU_IDLE    = 2'd0,
    CPU_RD_WAIT = 2'd1,
    CPU_RD_CAP  = 2'd2,
    CPU_ACK     = 2'd3
  } cpu_state_e;

endpackage

// File: rtl/vga_fb_wbuf.sv
// vga_fb_wbuf: single-entry posted-write buffer with address-match compare.
// Only built when VGA_FB_ARB_WPOST_EN is defined.
`ifdef VGA_FB_ARB_WPOST_EN
module vga_fb_wbuf
  import vga_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rstN,
  input  logic              i_load,
  input  logic              i_drain,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hit
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // Load and drain never coincide: the arbiter only loads into an empty entry.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_addr  <= i_addr;
      r_data  <= i_data;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_addr  = r_addr;
  assign o_data  = r_data;
  assign o_hit   = r_valid && (r_addr == i_addr);

endmodule
`endif

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scan-out and CPU.
// Define VGA_FB_ARB_WPOST_EN to add a single-entry posted-write buffer.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk25175KHz,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  cpu_state_e        r_state, w_nextState;
  logic              r_memEn, r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata, r_cpuRdata;
  logic              r_dispTag1, r_dispTag2;
  logic              w_idleReq, w_cpuIssue, w_bufLoad, w_bufHitRead, w_drain;
  logic              w_bufValid, w_bufHit;
  logic [ADDR_W-1:0] w_bufAddr;
  logic [DATA_W-1:0] w_bufData;

`ifdef VGA_FB_ARB_WPOST_EN
  localparam bit WPOST = 1'b1;

  vga_fb_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
    .i_clk   (clk25175KHz),
    .i_rstN  (reset_n),
    .i_load  (w_bufLoad),
    .i_drain (w_drain),
    .i_addr  (cpu_addr),
    .i_data  (cpu_wdata),
    .o_valid (w_bufValid),
    .o_addr  (w_bufAddr),
    .o_data  (w_bufData),
    .o_hit   (w_bufHit)
  );
`else
  localparam bit WPOST = 1'b0;

  assign w_bufValid = 1'b0;
  assign w_bufHit   = 1'b0;
  assign w_bufAddr  = '0;
  assign w_bufData  = '0;
`endif

  always_ff @(posedge clk25175KHz or negedge reset_n) begin
    if (!reset_n) r_state <= CPU_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CPU_IDLE: begin
        if (w_cpuIssue)                      w_nextState = cpu_we ? CPU_ACK : CPU_RD_WAIT;
        else if (w_bufLoad || w_bufHitRead)  w_nextState = CPU_ACK;
      end
      CPU_RD_WAIT: w_nextState = CPU_RD_CAP;
      CPU_RD_CAP:  w_nextState = CPU_ACK;
      CPU_ACK:     w_nextState = CPU_IDLE;
      default:     w_nextState = CPU_IDLE;
    endcase
  end

  // A pending buffered write blocks any RAM access by the CPU until it drains.
  always_comb begin
    w_idleReq    = (r_state == CPU_IDLE) && cpu_req;
    w_drain      = w_bufValid && !disp_req;
    w_bufHitRead = w_idleReq && !cpu_we && w_bufHit;
    w_cpuIssue   = w_idleReq && !w_bufValid && !disp_req;
    w_bufLoad    = WPOST && w_idleReq && cpu_we && !w_bufValid && disp_req;
    cpu_ack      = (r_state == CPU_ACK);
  end

  // One owner per memory cycle: display first, then buffer drain, then a CPU access.
  always_ff @(posedge clk25175KHz or negedge reset_n) begin
    if (!reset_n) begin
      r_memEn    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_dispTag1 <= 1'b0;
      r_dispTag2 <= 1'b0;
      r_cpuRdata <= '0;
    end else begin
      r_dispTag1 <= disp_req;
      r_dispTag2 <= r_dispTag1;
      r_memEn    <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      if (disp_req) begin
        r_memEn   <= 1'b1;
        r_memAddr <= disp_addr;
      end else if (w_drain) begin
        r_memEn    <= 1'b1;
        r_memWe    <= 1'b1;
        r_memAddr  <= w_bufAddr;
        r_memWdata <= w_bufData;
      end else if (w_cpuIssue) begin
        r_memEn    <= 1'b1;
        r_memWe    <= cpu_we;
        r_memAddr  <= cpu_addr;
        r_memWdata <= cpu_we ? cpu_wdata : '0;
      end
      if (r_state == CPU_RD_CAP)  r_cpuRdata <= mem_rdata;
      else if (w_bufHitRead)      r_cpuRdata <= w_bufData;
    end
  end

  // Display data is steered straight from the RAM port in the cycle its tag arrives.
  assign disp_valid = r_dispTag2;
  assign disp_data  = r_dispTag2 ? mem_rdata : '0;
  assign cpu_rdata  = r_cpuRdata;
  assign mem_en     = r_memEn;
  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: self-checking bench with a behavioural RAM and a cycle-level reference model.
// Posted-write scenarios are compiled in only when VGA_FB_ARB_WPOST_EN is defined.
module tb_vga_fb_arbiter;

  logic        clk25175KHz = 1'b0;
  logic        reset_n     = 1'b1;
  logic        disp_req    = 1'b0;
  logic [15:0] disp_addr   = '0;
  logic        disp_valid;
  logic [15:0] disp_data;
  logic        cpu_req     = 1'b0;
  logic        cpu_we      = 1'b0;
  logic [15:0] cpu_addr    = '0;
  logic [15:0] cpu_wdata   = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata   = '0;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] seed = 16'h5A3C;
  logic [15:0] ram     [0:65535];
  bit          written [0:65535];
  logic [15:0] refW    [int];

  typedef struct packed { logic v; logic [15:0] d; } dexp_t;

  vga_fb_arbiter dut (
    .clk25175KHz (clk25175KHz),
    .reset_n     (reset_n),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #20 clk25175KHz = ~clk25175KHz;

  // Untouched RAM words hold a seeded pattern so display data is never trivially zero.
  function automatic logic [15:0] initVal(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ seed;
  endfunction

  function automatic logic [15:0] refRead(input logic [15:0] a);
    if (refW.exists(int'(a))) return refW[int'(a)];
    return initVal(a);
  endfunction

  always @(posedge clk25175KHz) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : initVal(mem_addr);
      end
    end
  end

  task automatic tick;
    @(posedge clk25175KHz);
    #1;
  endtask

  task automatic test_reset;
    #1 reset_n = 1'b0;
    #4;
    vectors++; if (mem_en !== 1'b0)     begin miscompares++; $display("[TB] FAIL rst_mem_en got %b want 0", mem_en); end
    vectors++; if (mem_we !== 1'b0)     begin miscompares++; $display("[TB] FAIL rst_mem_we got %b want 0", mem_we); end
    vectors++; if (mem_addr !== 16'h0)  begin miscompares++; $display("[TB] FAIL rst_mem_addr got %h want 0", mem_addr); end
    vectors++; if (mem_wdata !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    vectors++; if (disp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_disp_valid got %b want 0", disp_valid); end
    vectors++; if (disp_data !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_disp_data got %h want 0", disp_data); end
    vectors++; if (cpu_ack !== 1'b0)    begin miscompares++; $display("[TB] FAIL rst_cpu_ack got %b want 0", cpu_ack); end
    vectors++; if (cpu_rdata !== 16'h0) begin miscompares++; $display("[TB] FAIL rst_cpu_rdata got %h want 0", cpu_rdata); end
    repeat (3) @(negedge clk25175KHz);
    reset_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_display_line;
    int validCount;
    logic expV;
    validCount = 0;
    for (int c = 0; c < 645; c++) begin
      tick();
      expV = (c >= 2 && c < 642);
      if (disp_valid === 1'b1) validCount++;
      vectors++; if (disp_valid !== expV) begin miscompares++; $display("[TB] FAIL line_valid c=%0d got %b want %b", c, disp_valid, expV); end
      if (expV) begin
        vectors++; if (disp_data !== refRead(16'(c - 2))) begin miscompares++; $display("[TB] FAIL line_data c=%0d got %h want %h", c, disp_data, refRead(16'(c - 2))); end
      end
      if (c >= 1 && c < 641) begin
        vectors++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 16'(c - 1)}) begin miscompares++; $display("[TB] FAIL line_mem c=%0d got en=%b we=%b a=%h want en=1 we=0 a=%h", c, mem_en, mem_we, mem_addr, 16'(c - 1)); end
      end
      disp_req  = (c < 640);
      disp_addr = 16'(c);
    end
    disp_req = 1'b0;
    vectors++; if (validCount != 640) begin miscompares++; $display("[TB] FAIL line_count got %0d want 640", validCount); end
  endtask

  task automatic test_cpu_write_read;
    int weCount;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'h1234;
    tick();
    vectors++; if (cpu_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ack_n1 got %b want 1", cpu_ack); end
    vectors++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0100, 16'h1234}) begin miscompares++; $display("[TB] FAIL wr_mem got en=%b we=%b a=%h d=%h want 1 1 0100 1234", mem_en, mem_we, mem_addr, mem_wdata); end
    cpu_req = 1'b0;
    refW[int'(16'h0100)] = 16'h1234;
    weCount = (mem_we === 1'b1) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_we === 1'b1) weCount++;
      vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ack_extra i=%0d got %b want 0", i, cpu_ack); end
    end
    vectors++; if (weCount != 1) begin miscompares++; $display("[TB] FAIL wr_we_count got %0d want 1", weCount); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 16'h0000;
    tick();
    vectors++; if ({mem_en, mem_we, mem_addr, cpu_ack} !== {2'b10, 16'h0100, 1'b0}) begin miscompares++; $display("[TB] FAIL rd_issue got en=%b we=%b a=%h ack=%b want 1 0 0100 0", mem_en, mem_we, mem_addr, cpu_ack); end
    tick();
    vectors++; if (cpu_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_ack_n2 got %b want 0", cpu_ack); end
    tick();
    vectors++; if (cpu_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ack_n3 got %b want 1", cpu_ack); end
    vectors++; if (cpu_rdata !== 16'h1234) begin miscompares++; $display("[TB] FAIL rd_data got %h want 1234", cpu_rdata); end
    cpu_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_cpu_during_burst;
    logic [15:0] dAddr [0:19];
    logic [15:0] rdAddr, expRd;
    logic        expV;
    rdAddr = 16'($urandom_range(0, 65535));
    expRd  = refRead(rdAddr);
    for (int c = 0; c < 20; c++) dAddr[c] = 16'($urandom);
    // Burst occupies cycles 2..11; the read raised at 4 issues in the first free cycle, 12.
    for (int c = 0; c < 20; c++) begin
      tick();
      expV = (c >= 4 && c <= 13);
      vectors++; if (disp_valid !== expV) begin miscompares++; $display("[TB] FAIL burst_valid c=%0d got %b want %b", c, disp_valid, expV); end
      if (expV) begin
        vectors++; if (disp_data !== refRead(dAddr[c - 2])) begin miscompares++; $display("[TB] FAIL burst_data c=%0d got %h want %h", c, disp_data, refRead(dAddr[c - 2])); end
      end
      if (c >= 3 && c <= 12) begin
        vectors++; if ({mem_en, mem_we, mem_addr} !== {2'b10, dAddr[c - 1]}) begin miscompares++; $display("[TB] FAIL burst_mem c=%0d got en=%b we=%b a=%h want display a=%h", c, mem_en, mem_we, mem_addr, dAddr[c - 1]); end
      end
      if (c == 13) begin
        vectors++; if ({mem_en, mem_we, mem_addr} !== {2'b10, rdAddr}) begin miscompares++; $display("[TB] FAIL burst_cpu_issue got en=%b we=%b a=%h want 1 0 %h", mem_en, mem_we, mem_addr, rdAddr); end
      end
      vectors++; if (cpu_ack !== (c == 15)) begin miscompares++; $display("[TB] FAIL burst_ack c=%0d got %b want %b", c, cpu_ack, (c == 15)); end
      if (c == 15) begin
        vectors++; if (cpu_rdata !== expRd) begin miscompares++; $display("[TB] FAIL burst_rdata got %h want %h", cpu_rdata, expRd); end
      end
      disp_req  = (c >= 2 && c <= 11);
      disp_addr = dAddr[c];
      cpu_req   = (c >= 4 && c < 15);
      cpu_we    = 1'b0;
      cpu_addr  = rdAddr;
    end
  endtask

  // Slot rule model: display owns any cycle it requests; a pending CPU access issues in the
  // next cycle without a display request; writes ack one cycle later, reads three.
  task automatic test_random_mix;
    localparam int NTX = 40;
    dexp_t       dq [$];
    dexp_t       e;
    bit          pending, issued, txWe, expEn, expWe;
    logic [15:0] txAddr, txData, expRd, expAddr;
    int          ackAt, nextStart, txDone;
    pending = 0; issued = 0; txWe = 0; expEn = 0; expWe = 0;
    txAddr = '0; txData = '0; expRd = '0; expAddr = '0;
    ackAt = -1; nextStart = 0; txDone = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      e = (dq.size() == 2) ? dq.pop_front() : dexp_t'(0);
      vectors++; if (disp_valid !== e.v) begin miscompares++; $display("[TB] FAIL mix_valid c=%0d got %b want %b", c, disp_valid, e.v); end
      if (e.v) begin
        vectors++; if (disp_data !== e.d) begin miscompares++; $display("[TB] FAIL mix_data c=%0d got %h want %h", c, disp_data, e.d); end
      end
      vectors++; if (mem_en !== expEn) begin miscompares++; $display("[TB] FAIL mix_mem_en c=%0d got %b want %b", c, mem_en, expEn); end
      if (expEn) begin
        vectors++; if ({mem_we, mem_addr} !== {expWe, expAddr}) begin miscompares++; $display("[TB] FAIL mix_mem c=%0d got we=%b a=%h want we=%b a=%h", c, mem_we, mem_addr, expWe, expAddr); end
      end
      vectors++; if (cpu_ack !== (c == ackAt)) begin miscompares++; $display("[TB] FAIL mix_ack c=%0d got %b want %b", c, cpu_ack, (c == ackAt)); end
      if (c == ackAt && !txWe) begin
        vectors++; if (cpu_rdata !== expRd) begin miscompares++; $display("[TB] FAIL mix_rdata c=%0d got %h want %h", c, cpu_rdata, expRd); end
      end
      if (c == ackAt) begin
        pending = 0; cpu_req = 1'b0; txDone++;
        nextStart = c + 1 + int'($urandom_range(0, 3));
      end
      if (!pending && txDone < NTX && c >= nextStart) begin
        pending = 1; issued = 0;
        txWe   = ($urandom_range(0, 1) == 1);
        txAddr = 16'($urandom_range(0, 63));
        txData = 16'($urandom);
        cpu_req = 1'b1; cpu_we = txWe; cpu_addr = txAddr; cpu_wdata = txData;
      end
      disp_req  = ($urandom_range(0, 99) < 55);
      disp_addr = 16'($urandom_range(0, 63));
      expEn = 0; expWe = 0; expAddr = '0;
      if (disp_req) begin
        dq.push_back('{1'b1, refRead(disp_addr)});
        expEn = 1; expAddr = disp_addr;
      end else begin
        dq.push_back(dexp_t'(0));
        if (pending && !issued) begin
          issued = 1; expEn = 1; expWe = txWe; expAddr = txAddr;
          ackAt = c + (txWe ? 1 : 3);
          if (txWe) refW[int'(txAddr)] = txData;
          else      expRd = refRead(txAddr);
        end
      end
      if (txDone == NTX && c > ackAt + 3) break;
    end
    disp_req = 1'b0; cpu_req = 1'b0;
    vectors++; if (txDone != NTX) begin miscompares++; $display("[TB] FAIL mix_tx_done got %0d want %0d", txDone, NTX); end
    repeat (3) tick();
  endtask

`ifdef VGA_FB_ARB_WPOST_EN
  // Burst in cycles 2..21: write posted at 4, hit-read at 6, second write held until drain at 22.
  task automatic test_posted_write;
    bit expAck;
    for (int c = 0; c < 28; c++) begin
      tick();
      expAck = (c == 5 || c == 7 || c == 24);
      vectors++; if (cpu_ack !== expAck) begin miscompares++; $display("[TB] FAIL wpost_ack c=%0d got %b want %b", c, cpu_ack, expAck); end
      if (c == 7) begin
        vectors++; if (cpu_rdata !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL wpost_hit got %h want beef", cpu_rdata); end
      end
      if (c == 23) begin
        vectors++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0200, 16'hBEEF}) begin miscompares++; $display("[TB] FAIL wpost_drain got we=%b a=%h d=%h", mem_we, mem_addr, mem_wdata); end
      end else if (c == 24) begin
        vectors++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 16'h0201, 16'hCAFE}) begin miscompares++; $display("[TB] FAIL wpost_second got we=%b a=%h d=%h", mem_we, mem_addr, mem_wdata); end
      end else begin
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL wpost_stray_we c=%0d got %b want 0", c, mem_we); end
      end
      disp_req  = (c >= 2 && c <= 21);
      disp_addr = 16'(c);
      cpu_req   = (c == 4) || (c == 6) || (c >= 8 && c < 24);
      cpu_we    = (c != 6);
      cpu_addr  = (c >= 8) ? 16'h0201 : 16'h0200;
      cpu_wdata = (c >= 8) ? 16'hCAFE : 16'hBEEF;
    end
    cpu_req = 1'b0;
    refW[int'(16'h0200)] = 16'hBEEF;
    refW[int'(16'h0201)] = 16'hCAFE;
  endtask
`endif

  task automatic test_reset_mid_read;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; disp_req = 1'b0;
    tick();
    vectors++; if (mem_en !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_issue got %b want 1", mem_en); end
    #4 reset_n = 1'b0;
    #1;
    vectors++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== 34'h0) begin miscompares++; $display("[TB] FAIL midrst_mem got en=%b we=%b a=%h d=%h want zeros", mem_en, mem_we, mem_addr, mem_wdata); end
    vectors++; if ({cpu_ack, cpu_rdata} !== 17'h0) begin miscompares++; $display("[TB] FAIL midrst_cpu got ack=%b rd=%h want zeros", cpu_ack, cpu_rdata); end
    vectors++; if ({disp_valid, disp_data} !== 17'h0) begin miscompares++; $display("[TB] FAIL midrst_disp got v=%b d=%h want zeros", disp_valid, disp_data); end
    cpu_req = 1'b0;
    repeat (2) @(negedge clk25175KHz);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++; if ({cpu_ack, mem_en} !== 2'b00) begin miscompares++; $display("[TB] FAIL midrst_after i=%0d got ack=%b en=%b want 0 0", i, cpu_ack, mem_en); end
    end
  endtask

  initial begin
    seed = 16'($urandom);
    $display("[TB] starting vga_fb_arbiter bench");
    test_reset();
    test_display_line();
    test_cpu_write_read();
    test_cpu_during_burst();
`ifdef VGA_FB_ARB_WPOST_EN
    test_posted_write();
`else
    test_random_mix();
`endif
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
